// File: rtl/spi_reg_bank_pkg.sv
// spi_reg_bank_pkg: shared field widths, R/W bit position and FSM states for the SPI register bank.
package spi_reg_bank_pkg;
    localparam int ADDR_FIELD_W = 7;
    localparam int CMD_W = 8;
    localparam int RW_BIT = 7;
    typedef enum logic [1:0] {IDLE, CMD, DATA, COMMIT} state_t;
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: 2-flop synchroniser for an asynchronous SPI pin with rise/fall pulse detection.
module spi_pin_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [2:0] sh;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sh <= '0;
        else sh <= {sh[1:0], pin};
    assign level = sh[1];
    assign rise = sh[1] & ~sh[2];
    assign fall = ~sh[1] & sh[2];
endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 target writing a bank of registers, all logic oversampled on clk.
// Define SPI_REG_BANK_READBACK_EN to compile in register readback on cipo.
module spi_reg_bank
    import spi_reg_bank_pkg::*;
#(
    parameter int NUM_REGS = 5,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       copi,
    input  logic                       ncs,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_FIELD_W-1:0]    wr_addr,
    output logic                       frame_err
);
    localparam int FRAME_W = CMD_W + DATA_W;
    localparam int CNT_W = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_CMD = CNT_W'(CMD_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(FRAME_W + 1);
    localparam logic [7:0] NREG = 8'(NUM_REGS);

    logic sclk_lvl, sclk_rise, sclk_fall, copi_lvl, copi_rise, copi_fall, ncs_lvl, ncs_rise, ncs_fall;
    spi_pin_sync u_sclk (.clk, .rst_n, .pin(sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
    spi_pin_sync u_copi (.clk, .rst_n, .pin(copi), .level(copi_lvl), .rise(copi_rise), .fall(copi_fall));
    spi_pin_sync u_ncs (.clk, .rst_n, .pin(ncs), .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall));

    logic unused_ok;
    assign unused_ok = ^{sclk_lvl, sclk_fall, copi_rise, copi_fall, ncs_lvl};

    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CMD_W-1:0] cmd, cmd_nxt;
    logic [DATA_W-1:0] data;
    logic in_frame, addr_ok, wr_ok, commit_wr;

    assign in_frame = (state == CMD) || (state == DATA);
    assign cmd_nxt = {cmd[CMD_W-2:0], copi_lvl};
    assign addr_ok = {1'b0, cmd[ADDR_FIELD_W-1:0]} < NREG;
    assign wr_ok = (cnt == CNT_FULL) && addr_ok;
    assign commit_wr = (state == COMMIT) && cmd[RW_BIT] && wr_ok;
    assign wr_strobe = commit_wr;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = ncs_fall ? CMD : IDLE;
            CMD:     state_nxt = ncs_rise ? IDLE : (cnt >= CNT_CMD ? DATA : CMD);
            DATA:    state_nxt = ncs_rise ? COMMIT : DATA;
            default: state_nxt = ncs_fall ? CMD : IDLE;
        endcase
    end

    // A new frame may open during COMMIT; the commit still sees the old fields this cycle.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            cmd <= '0;
            data <= '0;
            regs_flat <= '0;
            wr_addr <= '0;
        end else begin
            state <= state_nxt;
            if (ncs_fall) begin
                cnt <= '0;
                cmd <= '0;
                data <= '0;
            end else if (in_frame && sclk_rise) begin
                cnt <= (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
                if (cnt < CNT_CMD) cmd <= cmd_nxt;
                else data <= {data[DATA_W-2:0], copi_lvl};
            end
            if (commit_wr) wr_addr <= cmd[ADDR_FIELD_W-1:0];
            for (int i = 0; i < NUM_REGS; i++)
                if (commit_wr && cmd[ADDR_FIELD_W-1:0] == ADDR_FIELD_W'(i))
                    regs_flat[i*DATA_W +: DATA_W] <= data;
        end

`ifdef SPI_REG_BANK_READBACK_EN
    logic [DATA_W-1:0] tx, rd_word;
    logic rd_ok;
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (cmd_nxt[ADDR_FIELD_W-1:0] == ADDR_FIELD_W'(i)) rd_word = regs_flat[i*DATA_W +: DATA_W];
    end
    assign rd_ok = !cmd_nxt[RW_BIT] && ({1'b0, cmd_nxt[ADDR_FIELD_W-1:0]} < NREG);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            tx <= '0;
            cipo <= 1'b0;
            cipo_oe <= 1'b0;
        end else if (ncs_rise || ncs_fall) begin
            tx <= '0;
            cipo <= 1'b0;
            cipo_oe <= 1'b0;
        end else if (in_frame && sclk_rise && cnt == CNT_CMD - CNT_W'(1)) begin
            tx <= rd_ok ? rd_word : '0;
            cipo_oe <= rd_ok;
        end else if (cipo_oe && sclk_fall) begin
            cipo <= tx[DATA_W-1];
            tx <= {tx[DATA_W-2:0], 1'b0};
        end
    assign frame_err = (state == COMMIT) && (cmd[RW_BIT] ? !wr_ok : !addr_ok);
`else
    assign cipo = 1'b0;
    assign cipo_oe = 1'b0;
    assign frame_err = (state == COMMIT) && cmd[RW_BIT] && !wr_ok;
`endif
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: directed self-checking bench for spi_reg_bank (NUM_REGS=5, DATA_W=8).
module tb_spi_reg_bank;
    logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
    logic cipo, cipo_oe, wr_strobe, frame_err;
    logic [39:0] regs_flat;
    logic [6:0] wr_addr;
    logic [7:0] rx;
    logic oe_all, oe_any;
    int checks = 0, errors = 0, n_wr = 0, n_err = 0, wr0 = 0, err0 = 0;

    spi_reg_bank #(.NUM_REGS(5), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
        .cipo(cipo), .cipo_oe(cipo_oe), .regs_flat(regs_flat),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_strobe === 1'b1) n_wr <= n_wr + 1;
        if (frame_err === 1'b1) n_err <= n_err + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bits(input logic [63:0] bits, input int n);
        rx = '0;
        oe_all = 1'b1;
        oe_any = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            copi = bits[i];
            #50;
            if (n - 1 - i >= 8) begin
                rx = {rx[6:0], cipo};
                oe_all = oe_all & cipo_oe;
                oe_any = oe_any | cipo_oe;
            end
            sclk = 1'b1;
            #50;
            sclk = 1'b0;
        end
    endtask

    // ncs rises 40 time units (4 clk) before the task returns
    task automatic frame(input logic [63:0] bits, input int n);
        wr0 = n_wr;
        err0 = n_err;
        ncs = 1'b0;
        #100;
        send_bits(bits, n);
        #50;
        ncs = 1'b1;
        #40;
    endtask

    initial begin
        #2;
        check("reset_regs", regs_flat, 0);
        check("reset_wr_addr", wr_addr, 0);
        check("reset_wr_strobe", wr_strobe, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_cipo", cipo, 0);
        check("reset_cipo_oe", cipo_oe, 0);
        #30 rst_n = 1'b1;
        #200;

        frame(64'h80A5, 16);
        check("wr0_regs", regs_flat, 40'h00_00_00_00_A5);
        check("wr0_strobes", n_wr - wr0, 1);
        check("wr0_wr_addr", wr_addr, 0);
        check("wr0_no_err", n_err - err0, 0);
        #150;
        check("wr0_single_strobe", n_wr - wr0, 1);

        frame(64'h8577, 16);
        check("addr5_regs", regs_flat, 40'h00_00_00_00_A5);
        check("addr5_err", n_err - err0, 1);
        check("addr5_no_wr", n_wr - wr0, 0);
        #150;

        frame(64'h831, 12);
        check("len12_regs", regs_flat, 40'h00_00_00_00_A5);
        check("len12_err", n_err - err0, 1);
        #150;
        frame(64'h10625, 17);
        check("len17_regs", regs_flat, 40'h00_00_00_00_A5);
        check("len17_err", n_err - err0, 1);
        #150;
        frame(64'h8312_0000_0000, 48);
        check("len48_regs", regs_flat, 40'h00_00_00_00_A5);
        check("len48_err", n_err - err0, 1);
        check("len48_no_wr", n_wr - wr0, 0);
        #150;

        frame(64'h1F, 5);
        check("short_no_err", n_err - err0, 0);
        check("short_no_wr", n_wr - wr0, 0);
        #150;

        frame(64'h823C, 16);
        check("wr2_regs", regs_flat, 40'h00_00_3C_00_A5);
        check("wr2_wr_addr", wr_addr, 2);
        #150;

        frame(64'h0200, 16);
`ifdef SPI_REG_BANK_READBACK_EN
        check("rd2_data", rx, 8'h3C);
        check("rd2_oe_data_phase", oe_all, 1);
`else
        check("rd2_cipo_tied", rx, 0);
        check("rd2_oe_tied", oe_any, 0);
`endif
        check("rd2_oe_after", cipo_oe, 0);
        check("rd2_no_err", n_err - err0, 0);
        check("rd2_no_wr", n_wr - wr0, 0);
        #150;

        frame(64'h0600, 16);
`ifdef SPI_REG_BANK_READBACK_EN
        check("rd6_cipo", rx, 0);
        check("rd6_err", n_err - err0, 1);
`else
        check("rd6_silent", n_err - err0, 0);
`endif
        check("rd6_regs", regs_flat, 40'h00_00_3C_00_A5);
        #150;

        wr0 = n_wr;
        err0 = n_err;
        ncs = 1'b0;
        #100;
        send_bits(64'h207, 10);
        #50;
        rst_n = 1'b0;
        #20;
        check("midrst_regs", regs_flat, 0);
        check("midrst_wr_addr", wr_addr, 0);
        rst_n = 1'b1;
        #200;
        ncs = 1'b1;
        #100;
        check("midrst_no_wr", n_wr - wr0, 0);
        check("midrst_no_err", n_err - err0, 0);
        frame(64'h8155, 16);
        check("postrst_regs", regs_flat, 40'h00_00_00_55_00);
        check("postrst_wr_addr", wr_addr, 1);
        check("postrst_strobe", n_wr - wr0, 1);
        #150;

        frame(64'h8311, 16);
        check("b2b_first_addr", wr_addr, 3);
        check("b2b_first_regs", regs_flat, 40'h00_11_00_55_00);
        #60;
        frame(64'h8422, 16);
        check("b2b_second_addr", wr_addr, 4);
        check("b2b_second_regs", regs_flat, 40'h22_11_00_55_00);
        check("b2b_second_strobe", n_wr - wr0, 1);
        check("b2b_no_err", n_err - err0, 0);
        #150;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
